// File: rtl/cpu_phase_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cpu_phase_sequencer_pkg
// Shared constants for the instruction phase sequencer: encoded phase codes
// seen on PHASE, sequencer state encodings, and the default wait-state limit.
// Also provides a helper that maps a sequencer state to its phase code.
// ---------------------------------------------------------------------------
package cpu_phase_sequencer_pkg;

    // Encoded phase values driven on PHASE
    localparam logic [1:0] PHASE_FETCH   = 2'd0;
    localparam logic [1:0] PHASE_DECODE  = 2'd1;
    localparam logic [1:0] PHASE_EXECUTE = 2'd2;
    localparam logic [1:0] PHASE_COMMIT  = 2'd3;

    // Default number of wait cycles tolerated per memory phase
    localparam int unsigned DEFAULT_MAX_WAIT = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_EXEC2  = 3'd4,
        ST_COMMIT = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } seq_state_t;

    // IDLE, HALT and ERROR have no phase of their own and report 0
    function automatic logic [1:0] phase_of(input seq_state_t st);
        logic [1:0] ph;
        ph = PHASE_FETCH;
        case (st)
            ST_DECODE:          ph = PHASE_DECODE;
            ST_EXEC, ST_EXEC2:  ph = PHASE_EXECUTE;
            ST_COMMIT:          ph = PHASE_COMMIT;
            default:            ph = PHASE_FETCH;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/cpu_phase_sequencer_wait_timer.sv
// ---------------------------------------------------------------------------
// wait_timer
// Wait-state counter for a single memory phase. CLEAR has priority over
// ENABLE. The count holds once it reaches MAX_WAIT so it cannot wrap.
//   CLK     in   clock
//   RESET   in   asynchronous active-high reset (count -> 0)
//   CLEAR   in   synchronous clear
//   ENABLE  in   count one wait cycle
//   TC      out  terminal count: count == MAX_WAIT
// ---------------------------------------------------------------------------
module wait_timer #(
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLEAR,
    input  logic ENABLE,
    output logic TC
);

    localparam logic [WAIT_W-1:0] TC_VAL = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (CLEAR) begin
            count <= '0;
        end else if (ENABLE && !TC) begin
            count <= count + 1'b1;
        end
    end

    always_comb begin
        TC = (count == TC_VAL);
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_phase_sequencer
// Single source of instruction timing: steps FETCH -> DECODE -> EXECUTE
// (optionally a second EXECUTE cycle) -> COMMIT, stretching FETCH and
// memory EXECUTE cycles for wait states, with run/halt control and a sticky
// bus-timeout error.
//   CLK          in   system clock, rising edge
//   RESET        in   asynchronous active-high reset
//   RUN          in   1 = execute instructions
//   HALT_REQ     in   halt request, sampled in COMMIT (and held in HALT)
//   MEM_REQ      in   instruction accesses memory during EXECUTE
//   EXTRA_CYCLE  in   instruction needs a second execute cycle
//   MEM_READY    in   memory completes the current access this cycle
//   FETCH, DECODE, EXECUTE, EXEC2, COMMIT  out  phase strobes
//   MEM_STROBE   out  memory access active
//   STALL        out  MEM_STROBE & !MEM_READY
//   HALTED       out  core halted
//   BUS_ERR      out  sticky timeout flag
//   PHASE        out  encoded phase 0..3
// ---------------------------------------------------------------------------
module cpu_phase_sequencer
    import cpu_phase_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RUN,
    input  logic       HALT_REQ,
    input  logic       MEM_REQ,
    input  logic       EXTRA_CYCLE,
    input  logic       MEM_READY,
    output logic       FETCH,
    output logic       DECODE,
    output logic       EXECUTE,
    output logic       EXEC2,
    output logic       COMMIT,
    output logic       MEM_STROBE,
    output logic       STALL,
    output logic       HALTED,
    output logic       BUS_ERR,
    output logic [1:0] PHASE
);

    seq_state_t state;
    seq_state_t next_state;
    logic       timer_clear;
    logic       timer_tc;

    wait_timer #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .CLK    (CLK),
        .RESET  (RESET),
        .CLEAR  (timer_clear),
        .ENABLE (STALL),
        .TC     (timer_tc)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        MEM_STROBE = (state == ST_FETCH) || ((state == ST_EXEC) && MEM_REQ);
        STALL      = MEM_STROBE && !MEM_READY;

        case (state)
            ST_IDLE: begin
                if (RUN) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                // A ready in the terminal-count cycle still completes normally
                if (MEM_READY)     next_state = ST_DECODE;
                else if (timer_tc) next_state = ST_ERROR;
            end
            ST_DECODE: begin
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (!MEM_REQ || MEM_READY) begin
                    next_state = EXTRA_CYCLE ? ST_EXEC2 : ST_COMMIT;
                end else if (timer_tc) begin
                    next_state = ST_ERROR;
                end
            end
            ST_EXEC2: begin
                next_state = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (HALT_REQ)  next_state = ST_HALT;
                else if (!RUN) next_state = ST_IDLE;
                else           next_state = ST_FETCH;
            end
            ST_HALT: begin
                if (!HALT_REQ) next_state = RUN ? ST_FETCH : ST_IDLE;
            end
            ST_ERROR: begin
                next_state = ST_ERROR;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // Restart the wait count only on entry to a memory phase, not while
        // a stretched phase is being held
        timer_clear = ((next_state == ST_FETCH) && (state != ST_FETCH)) ||
                      ((next_state == ST_EXEC)  && (state != ST_EXEC));
    end

    always_comb begin
        FETCH   = (state == ST_FETCH);
        DECODE  = (state == ST_DECODE);
        EXECUTE = (state == ST_EXEC) || (state == ST_EXEC2);
        EXEC2   = (state == ST_EXEC2);
        COMMIT  = (state == ST_COMMIT);
        HALTED  = (state == ST_HALT);
        BUS_ERR = (state == ST_ERROR);
        PHASE   = phase_of(state);
    end

endmodule
